// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one memory bus port between two cache clients. Client 0 is the
//   instruction cache and client 1 is the data cache. Arbitration is
//   round-robin with one transaction outstanding at a time. The grant is held
//   from command accept until the store is accepted by memory or the load line
//   has been handed to the client.
//
//   Optional feature macro: ARB_TIMEOUT_EN. When it is defined, a load that gets
//   no memory response for TIMEOUT_CYCLES cycles in WAIT is completed towards
//   the client with an all-ones line and c_error set.
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   c_cmd_valid/_store  per-client command valid / store flag (bit i = client i)
//   c_cmd_addr/c_wdata  per-client line address / store line (slice i)
//   c_cmd_ready         one-cycle accept pulse to the winning client
//   c_resp_valid/ready  load line handshake with the granted client
//   c_rdata, c_error    shared load line, per-client timeout flag
//   mem_req_*           registered request towards memory
//   mem_resp_*          load line from memory
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int OFFSET_LENGTH  = 3,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int LINE_WIDTH    = DATA_WIDTH * (2 ** OFFSET_LENGTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              c_cmd_valid,
  input  logic [1:0]              c_cmd_store,
  input  logic [2*ADDR_WIDTH-1:0] c_cmd_addr,
  input  logic [2*LINE_WIDTH-1:0] c_wdata,
  output logic [1:0]              c_cmd_ready,
  output logic [1:0]              c_resp_valid,
  input  logic [1:0]              c_resp_ready,
  output logic [LINE_WIDTH-1:0]   c_rdata,
  output logic [1:0]              c_error,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_req_store,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic [LINE_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_resp_valid,
  output logic                    mem_resp_ready,
  input  logic [LINE_WIDTH-1:0]   mem_rdata
);

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_param_chk
    $error("mem_bus_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_WAIT    = 2'd2,
    S_DELIVER = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  // last_grant_q doubles as the current grant: they only differ before the
  // first grant, when no transaction is active.
  logic                    last_grant_q, last_grant_d;
  logic                    store_q, store_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LINE_WIDTH-1:0]   wdata_q, wdata_d;
  logic [LINE_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    win_s;
  logic [1:0]              cmd_ready_s;
  logic [1:0]              resp_valid_s;
  logic [1:0]              error_s;
  logic                    req_valid_s;
  logic                    resp_ready_s;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    err_q, err_d;
`endif

  // Tie goes to the client that did not win last time; otherwise the sole requester.
  assign win_s = (c_cmd_valid == 2'b11) ? ~last_grant_q : c_cmd_valid[1];

  // Next-state, register capture and output decode.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    store_d      = store_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    cmd_ready_s  = 2'b00;
    resp_valid_s = 2'b00;
    error_s      = 2'b00;
    req_valid_s  = 1'b0;
    resp_ready_s = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (|c_cmd_valid) begin
          cmd_ready_s[win_s] = 1'b1;
          store_d            = c_cmd_store[win_s];
          addr_d             = win_s ? c_cmd_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                     : c_cmd_addr[ADDR_WIDTH-1:0];
          wdata_d            = win_s ? c_wdata[2*LINE_WIDTH-1:LINE_WIDTH]
                                     : c_wdata[LINE_WIDTH-1:0];
          last_grant_d       = win_s;
          state_d            = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        req_valid_s = 1'b1;
        if (mem_req_ready) begin
          if (store_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT;
`ifdef ARB_TIMEOUT_EN
            cnt_d   = {CNT_W{1'b0}};
`endif
          end
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        resp_ready_s = 1'b1;
        if (mem_resp_valid) begin
          rdata_d = mem_rdata;
          state_d = S_DELIVER;
`ifdef ARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          // Watchdog expiry: complete the load with a poisoned line.
          rdata_d = {LINE_WIDTH{1'b1}};
          err_d   = 1'b1;
          state_d = S_DELIVER;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1'b1);
        end
`else
        else begin
          state_d = S_WAIT;
        end
`endif
      end
      S_DELIVER: begin
        resp_valid_s[last_grant_q] = 1'b1;
`ifdef ARB_TIMEOUT_EN
        error_s[last_grant_q]      = err_q;
`endif
        if (c_resp_ready[last_grant_q]) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DELIVER;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      store_q      <= 1'b0;
      addr_q       <= {ADDR_WIDTH{1'b0}};
      wdata_q      <= {LINE_WIDTH{1'b0}};
      rdata_q      <= {LINE_WIDTH{1'b0}};
`ifdef ARB_TIMEOUT_EN
      cnt_q        <= {CNT_W{1'b0}};
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      store_q      <= store_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      err_q        <= err_d;
`endif
    end
  end

  // The accept pulse is decoded from live inputs in IDLE, so it is masked
  // by reset to keep every output low while reset is asserted.
  assign c_cmd_ready    = cmd_ready_s & {2{reset}};
  assign c_resp_valid   = resp_valid_s;
  assign c_error        = error_s;
  assign c_rdata        = rdata_q;
  assign mem_req_valid  = req_valid_s;
  assign mem_req_store  = store_q;
  assign mem_req_addr   = addr_q;
  assign mem_wdata      = wdata_q;
  assign mem_resp_ready = resp_ready_s;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
  localparam int AW = 64;
  localparam int LW = 512;

  typedef struct packed {
    logic          store;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } mem_exp_t;

  typedef struct packed {
    logic [1:0]    who;
    logic [LW-1:0] data;
    logic [1:0]    err;
  } resp_exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [1:0]      c_cmd_valid = 2'b00;
  logic [1:0]      c_cmd_store = 2'b00;
  logic [2*AW-1:0] c_cmd_addr = '0;
  logic [2*LW-1:0] c_wdata = '0;
  logic [1:0]      c_cmd_ready;
  logic [1:0]      c_resp_valid;
  logic [1:0]      c_resp_ready = 2'b00;
  logic [LW-1:0]   c_rdata;
  logic [1:0]      c_error;
  logic            mem_req_valid;
  logic            mem_req_ready = 1'b0;
  logic            mem_req_store;
  logic [AW-1:0]   mem_req_addr;
  logic [LW-1:0]   mem_wdata;
  logic            mem_resp_valid = 1'b0;
  logic            mem_resp_ready;
  logic [LW-1:0]   mem_rdata = '0;

  int n_checks = 0;
  int n_pass   = 0;

  logic [1:0] exp_grant_q[$];
  mem_exp_t   exp_mem_q[$];
  resp_exp_t  exp_resp_q[$];

  localparam logic [LW-1:0] PAT_A5   = {64{8'hA5}};
  localparam logic [LW-1:0] PAT_BEEF = {16{32'hDEAD_BEEF}};
  localparam logic [LW-1:0] PAT_D    = {8{64'h1122_3344_5566_7788}};
  localparam logic [LW-1:0] PAT_W0   = {8{64'h0000_0000_CAFE_0000}};
  localparam logic [LW-1:0] PAT_W1   = {8{64'h1111_0000_0000_F00D}};
  localparam logic [LW-1:0] ONES     = {LW{1'b1}};

  mem_bus_arbiter #(
    .ADDR_WIDTH(64), .DATA_WIDTH(64), .OFFSET_LENGTH(3), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset),
    .c_cmd_valid(c_cmd_valid), .c_cmd_store(c_cmd_store),
    .c_cmd_addr(c_cmd_addr), .c_wdata(c_wdata),
    .c_cmd_ready(c_cmd_ready), .c_resp_valid(c_resp_valid),
    .c_resp_ready(c_resp_ready), .c_rdata(c_rdata), .c_error(c_error),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_store(mem_req_store), .mem_req_addr(mem_req_addr),
    .mem_wdata(mem_wdata), .mem_resp_valid(mem_resp_valid),
    .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard monitor: compares whenever the DUT presents a handshake.
  always @(negedge clk) begin
    logic [1:0] eg;
    mem_exp_t   em;
    resp_exp_t  er;
    if (reset) begin
      if (c_cmd_ready != 2'b00) begin
        if (exp_grant_q.size() == 0) chk("unexpected_cmd_ready", LW'(c_cmd_ready), '0);
        else begin
          eg = exp_grant_q.pop_front();
          chk("grant", LW'(c_cmd_ready), LW'(eg));
        end
      end
      if (mem_req_valid && mem_req_ready) begin
        if (exp_mem_q.size() == 0) chk("unexpected_mem_req", LW'(mem_req_valid), '0);
        else begin
          em = exp_mem_q.pop_front();
          chk("mem_store", LW'(mem_req_store), LW'(em.store));
          chk("mem_addr", LW'(mem_req_addr), LW'(em.addr));
          if (em.store) chk("mem_wdata", mem_wdata, em.wdata);
        end
      end
      if ((c_resp_valid & c_resp_ready) != 2'b00) begin
        if (exp_resp_q.size() == 0) chk("unexpected_resp", LW'(c_resp_valid), '0);
        else begin
          er = exp_resp_q.pop_front();
          chk("resp_client", LW'(c_resp_valid), LW'(er.who));
          chk("resp_data", c_rdata, er.data);
          chk("resp_error", LW'(c_error), LW'(er.err));
        end
      end
    end
  end

  // One clock: sample accepts at negedge, drop accepted requests after the edge.
  task automatic tick();
    logic [1:0] rs;
    @(negedge clk);
    rs = c_cmd_ready;
    @(posedge clk);
    #1;
    c_cmd_valid = c_cmd_valid & ~rs;
  endtask

  task automatic req(input int c, input logic st, input logic [AW-1:0] a, input logic [LW-1:0] w);
    c_cmd_valid[c]        = 1'b1;
    c_cmd_store[c]        = st;
    c_cmd_addr[c*AW +: AW] = a;
    c_wdata[c*LW +: LW]   = w;
  endtask

  task automatic push_mem(input logic st, input logic [AW-1:0] a, input logic [LW-1:0] w);
    mem_exp_t m;
    m.store = st; m.addr = a; m.wdata = w;
    exp_mem_q.push_back(m);
  endtask

  task automatic push_resp(input logic [1:0] who, input logic [LW-1:0] d, input logic [1:0] e);
    resp_exp_t r;
    r.who = who; r.data = d; r.err = e;
    exp_resp_q.push_back(r);
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while ((exp_grant_q.size() != 0 || exp_mem_q.size() != 0 || exp_resp_q.size() != 0 ||
            c_cmd_valid != 2'b00) && n < lim) begin
      tick();
      n++;
    end
    if (n >= lim) begin
      n_checks++;
      $display("FAIL drain_timeout: got %0d cycles, required under %0d", n, lim);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    c_cmd_valid = 2'b00; c_resp_ready = 2'b00;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    #1;
    chk("rst_cmd_ready", LW'(c_cmd_ready), '0);
    chk("rst_resp_valid", LW'(c_resp_valid), '0);
    chk("rst_error", LW'(c_error), '0);
    chk("rst_rdata", c_rdata, '0);
    chk("rst_mem_req_valid", LW'(mem_req_valid), '0);
    chk("rst_mem_req_addr", LW'(mem_req_addr), '0);
    chk("rst_mem_req_store", LW'(mem_req_store), '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_mem_resp_ready", LW'(mem_resp_ready), '0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    do_reset();

    // Single load from client 1, no contention.
    req(1, 1'b0, 64'h1000, '0);
    mem_req_ready = 1'b1;
    exp_grant_q.push_back(2'b10);
    push_mem(1'b0, 64'h1000, '0);
    #1;
    chk("t1_cmd_ready_c0", LW'(c_cmd_ready), LW'(2'b10));
    chk("t1_no_req_c0", LW'(mem_req_valid), '0);
    tick();
    chk("t1_req_valid", LW'(mem_req_valid), LW'(1'b1));
    chk("t1_req_addr", LW'(mem_req_addr), LW'(64'h1000));
    chk("t1_req_store", LW'(mem_req_store), '0);
    tick();
    chk("t1_resp_ready", LW'(mem_resp_ready), LW'(1'b1));
    tick();
    tick();
    mem_resp_valid = 1'b1;
    mem_rdata = PAT_A5;
    push_resp(2'b10, PAT_A5, 2'b00);
    tick();
    mem_resp_valid = 1'b0;
    chk("t1_resp_valid", LW'(c_resp_valid), LW'(2'b10));
    chk("t1_rdata", c_rdata, PAT_A5);
    chk("t1_resp_ready_off", LW'(mem_resp_ready), '0);
    c_resp_ready = 2'b10;
    tick();
    c_resp_ready = 2'b00;
    mem_req_ready = 1'b0;
    chk("t1_idle_resp_valid", LW'(c_resp_valid), '0);
    chk("t1_idle_req_valid", LW'(mem_req_valid), '0);

    // Simultaneous requests after reset, then a repeated tie.
    do_reset();
    mem_req_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req(0, 1'b1, 64'h00A0, PAT_W0);
      req(1, 1'b1, 64'h00A1, PAT_W1);
      exp_grant_q.push_back(2'b01); push_mem(1'b1, 64'h00A0, PAT_W0);
      exp_grant_q.push_back(2'b10); push_mem(1'b1, 64'h00A1, PAT_W1);
      drain(20);
    end
    mem_req_ready = 1'b0;

    // Store with memory backpressure.
    c_resp_ready = 2'b11;
    req(0, 1'b1, 64'h40, PAT_BEEF);
    exp_grant_q.push_back(2'b01);
    push_mem(1'b1, 64'h40, PAT_BEEF);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", LW'(mem_req_valid), LW'(1'b1));
      chk("t3_hold_addr", LW'(mem_req_addr), LW'(64'h40));
      chk("t3_hold_wdata", mem_wdata, PAT_BEEF);
      chk("t3_hold_store", LW'(mem_req_store), LW'(1'b1));
      tick();
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("t3_idle_req_valid", LW'(mem_req_valid), '0);
    chk("t3_no_resp", LW'(c_resp_valid), '0);
    c_resp_ready = 2'b00;

    // Client backpressure on load data; client 0 waits for DELIVER exit.
    mem_req_ready = 1'b1;
    req(1, 1'b0, 64'h2000, '0);
    exp_grant_q.push_back(2'b10);
    push_mem(1'b0, 64'h2000, '0);
    tick();
    tick();
    mem_resp_valid = 1'b1;
    mem_rdata = PAT_D;
    push_resp(2'b10, PAT_D, 2'b00);
    tick();
    mem_resp_valid = 1'b0;
    mem_rdata = '0;
    req(0, 1'b1, 64'h80, PAT_W0);
    exp_grant_q.push_back(2'b01);
    push_mem(1'b1, 64'h80, PAT_W0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t4_hold_resp_valid", LW'(c_resp_valid), LW'(2'b10));
      chk("t4_hold_rdata", c_rdata, PAT_D);
      chk("t4_no_accept", LW'(c_cmd_ready), '0);
      chk("t4_no_error", LW'(c_error), '0);
      tick();
    end
    c_resp_ready = 2'b10;
    #1;
    chk("t4_no_accept_on_exit", LW'(c_cmd_ready), '0);
    tick();
    c_resp_ready = 2'b00;
    #1;
    chk("t4_accept_after_exit", LW'(c_cmd_ready), LW'(2'b01));
    drain(20);
    mem_req_ready = 1'b0;

    // Async reset while in WAIT; first tie afterwards goes to client 0.
    mem_req_ready = 1'b1;
    req(0, 1'b0, 64'h300, '0);
    exp_grant_q.push_back(2'b01);
    push_mem(1'b0, 64'h300, '0);
    tick();
    tick();
    chk("t5_in_wait", LW'(mem_resp_ready), LW'(1'b1));
    #2;
    do_reset();
    mem_req_ready = 1'b1;
    req(0, 1'b1, 64'h00A0, PAT_W0);
    req(1, 1'b1, 64'h00A1, PAT_W1);
    exp_grant_q.push_back(2'b01); push_mem(1'b1, 64'h00A0, PAT_W0);
    exp_grant_q.push_back(2'b10); push_mem(1'b1, 64'h00A1, PAT_W1);
    drain(20);
    mem_req_ready = 1'b0;

`ifdef ARB_TIMEOUT_EN
    // Load with no memory response: watchdog completes it after 8 WAIT cycles.
    mem_req_ready = 1'b1;
    req(1, 1'b0, 64'h500, '0);
    exp_grant_q.push_back(2'b10);
    push_mem(1'b0, 64'h500, '0);
    tick();
    tick();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t6_waiting", LW'(c_resp_valid), '0);
      chk("t6_resp_ready", LW'(mem_resp_ready), LW'(1'b1));
      tick();
    end
    chk("t6_resp_valid", LW'(c_resp_valid), LW'(2'b10));
    chk("t6_error", LW'(c_error), LW'(2'b10));
    chk("t6_rdata_ones", c_rdata, ONES);
    chk("t6_resp_ready_off", LW'(mem_resp_ready), '0);
    mem_resp_valid = 1'b1;
    push_resp(2'b10, ONES, 2'b10);
    c_resp_ready = 2'b10;
    tick();
    mem_resp_valid = 1'b0;
    c_resp_ready = 2'b00;
    chk("t6_error_clear", LW'(c_error), '0);
    chk("t6_idle_resp", LW'(c_resp_valid), '0);
    tick();
    chk("t6_late_ignored", LW'(c_resp_valid), '0);
`endif

    tick();
    chk("grant_queue_empty", LW'(exp_grant_q.size()), '0);
    chk("mem_queue_empty", LW'(exp_mem_q.size()), '0);
    chk("resp_queue_empty", LW'(exp_resp_q.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
